// File: rtl/rgb_timing_decoder.sv
// RGB565 parallel-video receiver: recovers pixel coordinates, measures frame
// geometry and checksum, and tracks lock against the expected geometry.
module rgb_timing_decoder #(
  parameter int EXP_WIDTH   = 800,
  parameter int EXP_HEIGHT  = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1048576
) (
  input  logic        P_CLK,
  input  logic        RST,
  input  logic        DATA_EN,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic [4:0]  color_red,
  input  logic [5:0]  color_green,
  input  logic [4:0]  color_blue,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [15:0] pix_rgb,
  output logic        frame_start,
  output logic [10:0] meas_width,
  output logic [10:0] meas_height,
  output logic [10:0] meas_htot,
  output logic [15:0] frame_sum,
  output logic        locked,
  output logic        err_geom
);

  localparam logic [10:0] SAT = 11'h7FF;
  localparam int          WDW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [15:0] rgb;
  } s1_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } s2_t;

  typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCKED} state_t;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == SAT) ? v : v + 11'd1;
  endfunction

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic [10:0]    de_cnt_q, de_cnt_d;
  logic [10:0]    lines_q, lines_d;
  logic [10:0]    htot_cnt_q, htot_cnt_d;
  logic           hs_seen_q, hs_seen_d;
  logic           line_bad_q, line_bad_d;
  logic           drop_q, drop_d;
  logic [15:0]    acc_q, acc_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic        pix_valid_q, pix_valid_d;
  logic [10:0] pix_x_q, pix_x_d;
  logic [10:0] pix_y_q, pix_y_d;
  logic [15:0] pix_rgb_q, pix_rgb_d;
  logic        frame_start_q, frame_start_d;
  logic [10:0] meas_width_q, meas_width_d;
  logic [10:0] meas_height_q, meas_height_d;
  logic [10:0] meas_htot_q, meas_htot_d;
  logic [15:0] frame_sum_q, frame_sum_d;

  state_t      state_q;
  logic [3:0]  good_cnt_q;
  logic        locked_q, err_geom_q;

  logic        vs_fall, hs_fall, de_rise, de_fall, vs_de, line_end, emit;
  logic        bad_now, frame_good, timeout;
  logic [10:0] lines_now, x_now;
  logic [15:0] acc_now;
  logic [3:0]  gc_inc;

  always_comb begin
    s1_d = '{de: DATA_EN, hs: HSYNC, vs: VSYNC, rgb: {color_red, color_green, color_blue}};
    s2_d = '{de: s1_q.de, hs: s1_q.hs, vs: s1_q.vs};

    vs_fall  = s2_q.vs & ~s1_q.vs;
    hs_fall  = s2_q.hs & ~s1_q.hs;
    de_rise  = ~s2_q.de & s1_q.de;
    de_fall  = s2_q.de & ~s1_q.de;
    vs_de    = vs_fall & s1_q.de;
    // A line cut by VSYNC is ignored until the next DE rise.
    drop_d   = vs_de ? 1'b1 : (de_rise ? 1'b0 : drop_q);
    line_end = de_fall & ~drop_q;
    emit     = s1_q.de & ~drop_d;

    de_cnt_d = s1_q.de ? (de_rise ? 11'd1 : sat_inc(de_cnt_q)) : de_cnt_q;
    x_now    = de_rise ? 11'd0 : de_cnt_q;

    lines_now = line_end ? sat_inc(lines_q) : lines_q;
    bad_now   = line_bad_q | (line_end & (de_cnt_q != 11'(EXP_WIDTH)));
    acc_now   = emit ? (acc_q ^ s1_q.rgb) : acc_q;

    pix_valid_d = emit;
    pix_x_d     = emit ? x_now : pix_x_q;
    pix_y_d     = emit ? lines_q : pix_y_q;
    pix_rgb_d   = emit ? s1_q.rgb : pix_rgb_q;

    meas_width_d = line_end ? de_cnt_q : meas_width_q;

    htot_cnt_d  = hs_fall ? 11'd1 : sat_inc(htot_cnt_q);
    hs_seen_d   = hs_seen_q | hs_fall;
    meas_htot_d = (hs_fall & hs_seen_q) ? htot_cnt_q : meas_htot_q;

    frame_start_d = vs_fall;
    frame_good    = ~bad_now & ~vs_de & (lines_now == 11'(EXP_HEIGHT));
    if (vs_fall) begin
      meas_height_d = lines_now;
      frame_sum_d   = acc_q;
      acc_d         = '0;
      lines_d       = '0;
      line_bad_d    = vs_de;
    end else begin
      meas_height_d = meas_height_q;
      frame_sum_d   = frame_sum_q;
      acc_d         = acc_now;
      lines_d       = lines_now;
      line_bad_d    = bad_now;
    end

    timeout = ~vs_fall & (wd_q == WDW'(TIMEOUT - 1));
    if (vs_fall)                      wd_d = '0;
    else if (wd_q == WDW'(TIMEOUT))   wd_d = wd_q;
    else                              wd_d = wd_q + WDW'(1);

    gc_inc = good_cnt_q + 4'd1;
  end

  always_ff @(posedge P_CLK) begin
    if (RST) begin
      s1_q          <= '0;
      s2_q          <= '0;
      de_cnt_q      <= '0;
      lines_q       <= '0;
      htot_cnt_q    <= '0;
      hs_seen_q     <= 1'b0;
      line_bad_q    <= 1'b0;
      drop_q        <= 1'b0;
      acc_q         <= '0;
      wd_q          <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      frame_start_q <= 1'b0;
      meas_width_q  <= '0;
      meas_height_q <= '0;
      meas_htot_q   <= '0;
      frame_sum_q   <= '0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      de_cnt_q      <= de_cnt_d;
      lines_q       <= lines_d;
      htot_cnt_q    <= htot_cnt_d;
      hs_seen_q     <= hs_seen_d;
      line_bad_q    <= line_bad_d;
      drop_q        <= drop_d;
      acc_q         <= acc_d;
      wd_q          <= wd_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      frame_start_q <= frame_start_d;
      meas_width_q  <= meas_width_d;
      meas_height_q <= meas_height_d;
      meas_htot_q   <= meas_htot_d;
      frame_sum_q   <= frame_sum_d;
    end
  end

  // Lock FSM; the frame seen on the first VSYNC fall out of SEARCH is partial and not judged.
  always_ff @(posedge P_CLK) begin
    if (RST) begin
      state_q    <= ST_SEARCH;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_geom_q <= 1'b0;
    end else begin
      err_geom_q <= 1'b0;
      if (timeout) begin
        state_q    <= ST_SEARCH;
        good_cnt_q <= '0;
        locked_q   <= 1'b0;
      end else if (vs_fall) begin
        case (state_q)
          ST_SEARCH: begin
            state_q    <= ST_TRACK;
            good_cnt_q <= '0;
          end
          ST_TRACK: begin
            if (!frame_good) begin
              good_cnt_q <= '0;
            end else begin
              good_cnt_q <= gc_inc;
              if (gc_inc >= 4'(LOCK_FRAMES)) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end
          end
          ST_LOCKED: begin
            if (!frame_good) begin
              err_geom_q <= 1'b1;
              state_q    <= ST_TRACK;
              locked_q   <= 1'b0;
              good_cnt_q <= '0;
            end
          end
          default: begin
            state_q    <= ST_SEARCH;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_start = frame_start_q;
  assign meas_width  = meas_width_q;
  assign meas_height = meas_height_q;
  assign meas_htot   = meas_htot_q;
  assign frame_sum   = frame_sum_q;
  assign locked      = locked_q;
  assign err_geom    = err_geom_q;

endmodule

// File: tb/tb_rgb_timing_decoder.sv
// Directed bench for rgb_timing_decoder using a shrunken 8x6 geometry
// (14-clock lines, 10-line frames) so lock, watchdog and reset all fit in a short run.
module tb_rgb_timing_decoder;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int LF = 2;
  localparam int TO = 500;
  localparam int HT = 14;
  localparam int NL = 10;

  logic        P_CLK = 1'b0;
  logic        RST;
  logic        DATA_EN, HSYNC, VSYNC;
  logic [4:0]  color_red;
  logic [5:0]  color_green;
  logic [4:0]  color_blue;
  logic        pix_valid;
  logic [10:0] pix_x, pix_y;
  logic [15:0] pix_rgb;
  logic        frame_start;
  logic [10:0] meas_width, meas_height, meas_htot;
  logic [15:0] frame_sum;
  logic        locked, err_geom;

  int chk = 0;
  int pass = 0;

  int          fs_n = 0;
  int          err_n = 0;
  logic        fs_locked, fs_err;
  logic [10:0] fs_w, fs_h, fs_htot;
  logic [15:0] fs_sum;

  logic        probe_v;
  logic [10:0] probe_x, probe_y;
  logic [15:0] probe_rgb;

  rgb_timing_decoder #(
    .EXP_WIDTH(W), .EXP_HEIGHT(H), .LOCK_FRAMES(LF), .TIMEOUT(TO)
  ) dut (
    .P_CLK(P_CLK), .RST(RST), .DATA_EN(DATA_EN), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .color_red(color_red), .color_green(color_green), .color_blue(color_blue),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .meas_width(meas_width), .meas_height(meas_height),
    .meas_htot(meas_htot), .frame_sum(frame_sum), .locked(locked), .err_geom(err_geom)
  );

  always #5 P_CLK = ~P_CLK;

  // Snapshot everything the frame boundary reports.
  always @(negedge P_CLK) begin
    if (frame_start) begin
      fs_n      <= fs_n + 1;
      fs_locked <= locked;
      fs_err    <= err_geom;
      fs_w      <= meas_width;
      fs_h      <= meas_height;
      fs_htot   <= meas_htot;
      fs_sum    <= frame_sum;
    end
    if (err_geom) err_n <= err_n + 1;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge P_CLK);
      VSYNC = 1'b1; HSYNC = 1'b1; DATA_EN = 1'b0;
      {color_red, color_green, color_blue} = 16'h0;
    end
  endtask

  // One frame: lines 0-1 VSYNC low, line 2 blank, lines 3-8 active (DE at clocks 4..4+w-1).
  task automatic send_frame(input int short_act, input logic [15:0] fill, input int sp_act,
                            input int sp_x, input logic [15:0] sp_val, input int pk,
                            input int cut_k, input bit de_head);
    int k, act, w;
    bit de;
    for (int l = 0; l < NL; l++) begin
      for (int c = 0; c < HT; c++) begin
        k = l * HT + c;
        if (k == cut_k) return;
        @(negedge P_CLK);
        if (k == pk + 2) begin
          probe_v = pix_valid; probe_x = pix_x; probe_y = pix_y; probe_rgb = pix_rgb;
        end
        act = l - 3;
        w   = (act == short_act) ? W - 1 : W;
        de  = (act >= 0 && act < H && c >= 4 && c < 4 + w) || (de_head && l == 0 && c < 3);
        VSYNC   = (l >= 2);
        HSYNC   = (c >= 2);
        DATA_EN = de;
        {color_red, color_green, color_blue} =
          !de ? 16'h0 : ((act == sp_act && c - 4 == sp_x) ? sp_val : fill);
      end
    end
  endtask

  task automatic good_frame();
    send_frame(-1, 16'h0, -1, 0, 16'h0, -10, -1, 1'b0);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle(3);
    chk++; if (pix_valid !== 1'b0) $display("FAIL rst_pix_valid: got %0b want 0", pix_valid); else pass++;
    chk++; if ({pix_x, pix_y} !== 22'h0) $display("FAIL rst_pix_xy: got %0h want 0", {pix_x, pix_y}); else pass++;
    chk++; if (pix_rgb !== 16'h0) $display("FAIL rst_pix_rgb: got %0h want 0", pix_rgb); else pass++;
    chk++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start: got %0b want 0", frame_start); else pass++;
    chk++; if ({meas_width, meas_height, meas_htot} !== 33'h0)
      $display("FAIL rst_meas: got %0h want 0", {meas_width, meas_height, meas_htot}); else pass++;
    chk++; if (frame_sum !== 16'h0) $display("FAIL rst_frame_sum: got %0h want 0", frame_sum); else pass++;
    chk++; if ({locked, err_geom} !== 2'b00) $display("FAIL rst_lock_err: got %0b want 00", {locked, err_geom}); else pass++;
    @(negedge P_CLK); RST = 1'b0;
    idle(5);
  endtask

  task automatic test_lock();
    good_frame();
    chk++; if (fs_n !== 1) $display("FAIL lock_first_fs: got %0d frame_starts want 1", fs_n); else pass++;
    chk++; if (fs_locked !== 1'b0) $display("FAIL lock_fs1: locked=%0b want 0", fs_locked); else pass++;
    good_frame();
    chk++; if (fs_locked !== 1'b0) $display("FAIL lock_fs2: locked=%0b want 0", fs_locked); else pass++;
    probe_v = 1'b0;
    send_frame(-1, 16'h0, 5, 0, 16'hF800, (3 + 5) * HT + 4, -1, 1'b0);
    chk++; if (fs_locked !== 1'b1) $display("FAIL lock_fs3: locked=%0b want 1", fs_locked); else pass++;
    chk++; if (fs_w !== 11'd8) $display("FAIL lock_width: got %0d want 8", fs_w); else pass++;
    chk++; if (fs_h !== 11'd6) $display("FAIL lock_height: got %0d want 6", fs_h); else pass++;
    chk++; if (fs_htot !== 11'd14) $display("FAIL lock_htot: got %0d want 14", fs_htot); else pass++;
    chk++; if (probe_v !== 1'b1) $display("FAIL coord_valid: got %0b want 1", probe_v); else pass++;
    chk++; if (probe_x !== 11'd0) $display("FAIL coord_x: got %0d want 0", probe_x); else pass++;
    chk++; if (probe_y !== 11'd5) $display("FAIL coord_y: got %0d want 5", probe_y); else pass++;
    chk++; if (probe_rgb !== 16'hF800) $display("FAIL coord_rgb: got %0h want f800", probe_rgb); else pass++;
  endtask

  task automatic test_bad_line();
    int e0;
    e0 = err_n;
    send_frame(2, 16'h0, -1, 0, 16'h0, -10, -1, 1'b0);
    chk++; if (fs_locked !== 1'b1) $display("FAIL bad_prev_locked: got %0b want 1", fs_locked); else pass++;
    chk++; if (fs_sum !== 16'hF800) $display("FAIL sum_single: got %0h want f800", fs_sum); else pass++;
    good_frame();
    chk++; if (fs_err !== 1'b1) $display("FAIL bad_err_geom: got %0b want 1", fs_err); else pass++;
    chk++; if (fs_locked !== 1'b0) $display("FAIL bad_unlock: got %0b want 0", fs_locked); else pass++;
    chk++; if (fs_w !== 11'd8) $display("FAIL bad_last_width: got %0d want 8", fs_w); else pass++;
    chk++; if (err_n - e0 !== 1) $display("FAIL bad_err_cycles: got %0d want 1", err_n - e0); else pass++;
    good_frame();
    good_frame();
    chk++; if (fs_locked !== 1'b1) $display("FAIL bad_relock: got %0b want 1", fs_locked); else pass++;
  endtask

  task automatic test_checksum();
    send_frame(-1, 16'h0, 3, 4, 16'h1234, -10, -1, 1'b0);
    send_frame(-1, 16'h0001, -1, 0, 16'h0, -10, -1, 1'b0);
    chk++; if (fs_sum !== 16'h1234) $display("FAIL sum_1234: got %0h want 1234", fs_sum); else pass++;
    good_frame();
    chk++; if (fs_sum !== 16'h0000) $display("FAIL sum_even: got %0h want 0", fs_sum); else pass++;
    chk++; if (fs_locked !== 1'b1) $display("FAIL sum_locked: got %0b want 1", fs_locked); else pass++;
  endtask

  task automatic test_watchdog();
    int n0, e0;
    n0 = fs_n; e0 = err_n;
    chk++; if (locked !== 1'b1) $display("FAIL wd_pre_locked: got %0b want 1", locked); else pass++;
    idle(TO + 20);
    chk++; if (locked !== 1'b0) $display("FAIL wd_unlock: got %0b want 0", locked); else pass++;
    chk++; if (err_n !== e0) $display("FAIL wd_no_err: got %0d pulses want 0", err_n - e0); else pass++;
    chk++; if (fs_n !== n0) $display("FAIL wd_no_fs: got %0d frame_starts want 0", fs_n - n0); else pass++;
    good_frame();
    chk++; if ({fs_locked, fs_err} !== 2'b00) $display("FAIL wd_search: lock/err=%0b want 00", {fs_locked, fs_err}); else pass++;
    good_frame();
    good_frame();
    chk++; if (fs_locked !== 1'b1) $display("FAIL wd_relock: got %0b want 1", fs_locked); else pass++;
  endtask

  task automatic test_vs_during_de();
    int e0;
    send_frame(-1, 16'h0, -1, 0, 16'h0, -10, 5 * HT + 8, 1'b0);
    chk++; if (fs_locked !== 1'b1) $display("FAIL vsde_pre_locked: got %0b want 1", fs_locked); else pass++;
    e0 = err_n;
    probe_v = 1'b1;
    send_frame(-1, 16'h00FF, -1, 0, 16'h0, 0, -1, 1'b1);
    chk++; if (probe_v !== 1'b0) $display("FAIL vsde_pix_suppressed: got %0b want 0", probe_v); else pass++;
    chk++; if (fs_err !== 1'b1) $display("FAIL vsde_err: got %0b want 1", fs_err); else pass++;
    chk++; if (fs_h !== 11'd2) $display("FAIL vsde_height: got %0d want 2", fs_h); else pass++;
    chk++; if (err_n - e0 !== 1) $display("FAIL vsde_err_cycles: got %0d want 1", err_n - e0); else pass++;
    good_frame();
    chk++; if (fs_h !== 11'd6) $display("FAIL vsde_next_height: got %0d want 6", fs_h); else pass++;
    chk++; if ({fs_locked, fs_err} !== 2'b00) $display("FAIL vsde_next_bad: lock/err=%0b want 00", {fs_locked, fs_err}); else pass++;
    good_frame();
    chk++; if (fs_locked !== 1'b0) $display("FAIL vsde_track1: got %0b want 0", fs_locked); else pass++;
    send_frame(-1, 16'h0, 1, 2, 16'h00AB, -10, -1, 1'b0);
    chk++; if (fs_locked !== 1'b1) $display("FAIL vsde_relock: got %0b want 1", fs_locked); else pass++;
  endtask

  task automatic test_reset_mid();
    int n0;
    send_frame(-1, 16'h5A5A, -1, 0, 16'h0, -10, 6 * HT + 6, 1'b0);
    chk++; if (fs_sum !== 16'h00AB) $display("FAIL mid_pre_sum: got %0h want ab", fs_sum); else pass++;
    chk++; if (locked !== 1'b1) $display("FAIL mid_pre_locked: got %0b want 1", locked); else pass++;
    @(negedge P_CLK);
    RST = 1'b1; DATA_EN = 1'b0; VSYNC = 1'b1; HSYNC = 1'b1;
    @(negedge P_CLK);
    chk++; if ({pix_valid, pix_x, pix_y, pix_rgb} !== 39'h0)
      $display("FAIL mid_rst_pix: got %0h want 0", {pix_valid, pix_x, pix_y, pix_rgb}); else pass++;
    chk++; if ({meas_width, meas_height, meas_htot, frame_sum} !== 49'h0)
      $display("FAIL mid_rst_meas: got %0h want 0", {meas_width, meas_height, meas_htot, frame_sum}); else pass++;
    chk++; if ({frame_start, locked, err_geom} !== 3'b000)
      $display("FAIL mid_rst_ctl: got %0b want 000", {frame_start, locked, err_geom}); else pass++;
    @(negedge P_CLK); RST = 1'b0;
    idle(5);
    n0 = fs_n;
    good_frame();
    chk++; if (fs_n - n0 !== 1) $display("FAIL mid_first_fs: got %0d want 1", fs_n - n0); else pass++;
    chk++; if (fs_locked !== 1'b0) $display("FAIL mid_first_unlocked: got %0b want 0", fs_locked); else pass++;
    good_frame();
    good_frame();
    chk++; if (fs_locked !== 1'b1) $display("FAIL mid_relock: got %0b want 1", fs_locked); else pass++;
  endtask

  initial begin
    RST = 1'b1; DATA_EN = 1'b0; HSYNC = 1'b1; VSYNC = 1'b1;
    {color_red, color_green, color_blue} = 16'h0;
    test_reset();
    test_lock();
    test_bad_line();
    test_checksum();
    test_watchdog();
    test_vs_during_de();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: run exceeded time limit");
    $fatal(1);
  end

endmodule
